host_mem_responder: RTL and testbench
=====================================

Name: host_mem_responder

Overview:
- Slave/responder end of the engine DMA bus (arb_req/arb_we/arb_addr/arb_wdata -> arb_valid/arb_rdata).
- Backs a single-port on-chip word memory that an NTT engine streams LOAD_CONFIG/LOAD_DATA reads from and STORE_DATA writes into.
- Accepts one request per cycle and returns read data at a fixed pipelined latency; write requests get no response.
- A secondary low-priority host port preloads and inspects memory. Three counters (reads, writes, errors) support bring-up.

Parameters:
- BASE_ADDR, 48'h0, byte address mapped to word 0.
- MEM_LOG, 13, log2 of memory depth in 64-bit words (8192 words).
- RD_LATENCY, 2, cycles from accepted read to arb_valid; legal range 1..4.
- ERR_DATA, 64'hDEAD_BEEF_DEAD_BEEF, data returned for faulted reads.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- arb_req  in  1  engine request valid, one request per asserted cycle.
- arb_we  in  1  1 = write, 0 = read; qualified by arb_req.
- arb_addr  in  48  byte address.
- arb_wdata  in  64  write data.
- arb_valid  out  1  read response valid, one-cycle pulse per read.
- arb_rdata  out  64  read response data.
- host_req  in  1  host access request.
- host_we  in  1  host write enable.
- host_idx  in  MEM_LOG  host word index.
- host_wdata  in  64  host write data.
- host_gnt  out  1  combinational grant; host_req & ~arb_req.
- host_rvalid  out  1  host read data valid, 1 cycle after granted read.
- host_rdata  out  64  host read data.
- rd_count  out  16  accepted engine reads, saturating.
- wr_count  out  16  accepted engine writes, saturating.
- err_count  out  16  faulted engine accesses, saturating.

Behaviour:
- Reset (rst==0 at posedge) clears all of the following to 0: arb_valid, arb_rdata, host_rvalid, host_rdata, all three counters, and every read-pipeline valid bit.
- Memory contents are NOT cleared by reset. In-flight reads are discarded: no arb_valid follows a reset, even one asserted mid-stream.
- Decode: off = arb_addr - BASE_ADDR (48-bit). The access is a fault if arb_addr < BASE_ADDR, off[2:0] != 0, or off[47:3] >= 2**MEM_LOG. Otherwise idx = off[MEM_LOG+2:3].
- Engine read (arb_req=1, arb_we=0) accepted in cycle T:
  - arb_valid=1 in cycle T+RD_LATENCY exactly, for one cycle.
  - arb_rdata = mem[idx] as of the end of cycle T, or ERR_DATA if faulted.
  - Back-to-back reads produce back-to-back responses in order. There is no stall and no backpressure.
- Engine write (arb_req=1, arb_we=1): mem[idx] <= arb_wdata at the posedge ending cycle T. No response is generated. Faulted writes are dropped.
- Read-after-write: a read in cycle T+1 to a location written in cycle T returns the new data.
- arb_rdata holds its last value when arb_valid=0.
- Counters:
  - rd_count or wr_count increments on each accepted non-faulted engine access.
  - err_count increments on each faulted engine access; a fault does not touch rd_count or wr_count.
  - All three saturate at 16'hFFFF.
- Host port:
  - Served only in cycles with arb_req=0; the engine always wins.
  - A host write in a granted cycle commits at that edge.
  - A host read in a granted cycle gives host_rvalid=1 and host_rdata=mem[host_idx] in the next cycle.
  - host_req held without grant is simply not served; the host must re-present the request.
- The engine read pipeline and host read path are independent. A host read granted in cycle T and an engine response due in T+1 may both be valid in T+1.
- Memory is one write port plus one read port per cycle; engine and host never access it in the same cycle, by construction.
- Memory is inferred as array plus registered read.

Test Plan:
- Preload via host: idx 0..2 = 64'h1, 64'h2, 64'h3. Engine reads addr BASE+0, +8, +16 in consecutive cycles T..T+2 -> arb_valid high in T+2..T+4 with rdata 1, 2, 3; rd_count=3.
- 4096-word streaming read of preloaded pattern mem[i]=i*0x1111 (RD_LATENCY=2) -> exactly 4096 arb_valid pulses, contiguous, in order, all data match; rd_count=4096.
- Engine writes 4096 words data=~i, then host reads idx 0, 4095 -> host_rvalid with 64'hFFFF_FFFF_FFFF_FFFF and 64'hFFFF_FFFF_FFFF_F000; wr_count=4096.
- Faults: read at BASE+4 (misaligned) and read at BASE+8*8192 -> both return ERR_DATA at T+RD_LATENCY; err_count=2; rd_count unchanged. A write at BASE+8*8192 changes no memory word.
- Contention: host_req held during engine burst of 10 reads -> host_gnt=0 for all 10 cycles, granted the first cycle arb_req=0, host_rvalid the next cycle.
- Reset mid-stream: assert rst=0 the cycle after 3 reads are issued -> no arb_valid afterwards, all counters 0, previously preloaded memory still readable via host.

Source files
------------

// File: rtl/host_mem_responder.sv
// host_mem_responder
// Responder end of the engine DMA bus backed by a single-port on-chip word
// memory. Engine reads return data at a fixed pipelined latency and engine
// writes commit silently. A low-priority host port can preload and inspect
// the memory whenever the engine is idle. Three saturating counters track
// accepted reads, accepted writes and faulted engine accesses.

module host_mem_responder #(
    parameter logic [47:0] BASE_ADDR  = 48'h0,
    parameter int          MEM_LOG    = 13,
    parameter int          RD_LATENCY = 2,
    parameter logic [63:0] ERR_DATA   = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arb_req,
    input  logic               arb_we,
    input  logic [47:0]        arb_addr,
    input  logic [63:0]        arb_wdata,
    output logic               arb_valid,
    output logic [63:0]        arb_rdata,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [MEM_LOG-1:0] host_idx,
    input  logic [63:0]        host_wdata,
    output logic               host_gnt,
    output logic               host_rvalid,
    output logic [63:0]        host_rdata,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count,
    output logic [15:0]        err_count
);

    localparam int DEPTH = 1 << MEM_LOG;

    logic [63:0]        mem [DEPTH];

    logic [47:0]        off;
    logic               addr_fault;
    logic [MEM_LOG-1:0] eng_idx;

    logic               eng_rd_any;
    logic               eng_rd_ok;
    logic               eng_wr_ok;
    logic               eng_fault;
    logic               host_rd;
    logic               host_wr;

    logic               mem_we;
    logic [MEM_LOG-1:0] mem_waddr;
    logic [63:0]        mem_wdata;
    logic [MEM_LOG-1:0] mem_raddr;

    logic [RD_LATENCY-1:0] pipe_valid;
    logic [63:0]           pipe_data [RD_LATENCY];

    // Address decode: below-base, misaligned and beyond-depth accesses fault.
    // Checking the bits above the index field covers off[47:3] >= depth.
    assign off        = arb_addr - BASE_ADDR;
    assign addr_fault = (arb_addr < BASE_ADDR)
                      || (off[2:0] != 3'b000)
                      || (off[47:MEM_LOG+3] != '0);
    assign eng_idx    = off[MEM_LOG+2:3];

    // Request qualification; the engine always wins the memory.
    assign eng_rd_any = arb_req & ~arb_we;
    assign eng_rd_ok  = eng_rd_any & ~addr_fault;
    assign eng_wr_ok  = arb_req & arb_we & ~addr_fault;
    assign eng_fault  = arb_req & addr_fault;

    assign host_gnt   = host_req & ~arb_req;
    assign host_rd    = host_gnt & ~host_we;
    assign host_wr    = host_gnt & host_we;

    // One write port and one read port, shared by construction: the engine
    // owns both whenever arb_req is high, otherwise the host does.
    assign mem_we     = eng_wr_ok | host_wr;
    assign mem_waddr  = arb_req ? eng_idx   : host_idx;
    assign mem_wdata  = arb_req ? arb_wdata : host_wdata;
    assign mem_raddr  = arb_req ? eng_idx   : host_idx;

    // Memory array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read-pipeline valid bits: every engine read (faulted or not) produces
    // exactly one response RD_LATENCY cycles later; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= eng_rd_any;
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
            end
        end
    end

    // Read-pipeline data: stage 0 is the registered memory read, later stages
    // only advance behind a valid token so the last stage holds between pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_data[k] <= '0;
            end
        end else begin
            if (eng_rd_any) begin
                pipe_data[0] <= addr_fault ? ERR_DATA : mem[mem_raddr];
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                if (pipe_valid[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
        end
    end

    assign arb_valid = pipe_valid[RD_LATENCY-1];
    assign arb_rdata = pipe_data[RD_LATENCY-1];

    // Host read path: single registered read, valid the cycle after the grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_rvalid <= host_rd;
            if (host_rd) begin
                host_rdata <= mem[mem_raddr];
            end
        end
    end

    // Bring-up counters, each saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count  <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else begin
            if (eng_rd_ok && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
            if (eng_wr_ok && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
            if (eng_fault && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_host_mem_responder.sv
// Testbench for host_mem_responder: directed table, hand-written corner
// sequences and a randomized mix, all checked against a cycle-level model
// built from address arithmetic, a response queue and a word array.

module tb_host_mem_responder;

    localparam logic [47:0] BASE  = 48'h0000_0010_0000;
    localparam int          LAT   = 2;
    localparam int          MLOG  = 13;
    localparam int          DEPTH = 8192;
    localparam logic [63:0] ERRD  = 64'hDEAD_BEEF_DEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst;
    logic            arb_req, arb_we;
    logic [47:0]     arb_addr;
    logic [63:0]     arb_wdata;
    logic            arb_valid;
    logic [63:0]     arb_rdata;
    logic            host_req, host_we;
    logic [MLOG-1:0] host_idx;
    logic [63:0]     host_wdata;
    logic            host_gnt, host_rvalid;
    logic [63:0]     host_rdata;
    logic [15:0]     rd_count, wr_count, err_count;

    host_mem_responder #(
        .BASE_ADDR (BASE),
        .MEM_LOG   (MLOG),
        .RD_LATENCY(LAT),
        .ERR_DATA  (ERRD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arb_req    (arb_req),
        .arb_we     (arb_we),
        .arb_addr   (arb_addr),
        .arb_wdata  (arb_wdata),
        .arb_valid  (arb_valid),
        .arb_rdata  (arb_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_idx   (host_idx),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst_n;
        logic            a_req;
        logic            a_we;
        logic [47:0]     a_addr;
        logic [63:0]     a_wdata;
        logic            h_req;
        logic            h_we;
        logic [MLOG-1:0] h_idx;
        logic [63:0]     h_wdata;
        logic            e_valid;
        logic [63:0]     e_rdata;
        logic            e_gnt;
    } vec_t;

    typedef struct {
        int          due;
        logic [63:0] data;
    } resp_t;

    // Reference model state
    resp_t       exp_q[$];
    logic [63:0] mem_m [DEPTH];
    int          m_rd, m_wr, m_err;
    logic [63:0] last_rdata;
    bit          host_pend;
    bit          host_chk;
    logic [63:0] host_exp;

    int          cyc;
    int          pulses;
    int          n_vec;
    int          n_miss;
    vec_t        cur;
    vec_t        tbl[10];

    function automatic vec_t idle_v();
        vec_t v;
        v.rst_n = 1'b1; v.a_req = 1'b0; v.a_we = 1'b0; v.a_addr = '0; v.a_wdata = '0;
        v.h_req = 1'b0; v.h_we = 1'b0; v.h_idx = '0; v.h_wdata = '0;
        v.e_valid = 1'b0; v.e_rdata = '0; v.e_gnt = 1'b0;
        return v;
    endfunction

    function automatic vec_t rst_v();
        vec_t v = idle_v();
        v.rst_n = 1'b0;
        return v;
    endfunction

    function automatic vec_t eng_v(input logic we, input logic [47:0] addr, input logic [63:0] wd);
        vec_t v = idle_v();
        v.a_req = 1'b1; v.a_we = we; v.a_addr = addr; v.a_wdata = wd;
        return v;
    endfunction

    function automatic vec_t host_v(input logic we, input int idx, input logic [63:0] wd);
        vec_t v = idle_v();
        v.h_req = 1'b1; v.h_we = we; v.h_idx = MLOG'(idx); v.h_wdata = wd;
        return v;
    endfunction

    function automatic vec_t exp_v(input vec_t v, input logic ev, input logic [63:0] ed, input logic eg);
        vec_t r = v;
        r.e_valid = ev; r.e_rdata = ed; r.e_gnt = eg;
        return r;
    endfunction

    function automatic logic [47:0] waddr(input int i);
        return BASE + 48'(i) * 48'd8;
    endfunction

    // Address decode from the arithmetic rules, on 64-bit integers.
    function automatic bit decode(input logic [47:0] a, output int idx);
        longint unsigned av, bv, o;
        av  = {16'b0, a};
        bv  = {16'b0, BASE};
        idx = 0;
        if (av < bv) return 1'b1;
        o = av - bv;
        if (o % 8 != 0) return 1'b1;
        if (o / 8 >= DEPTH) return 1'b1;
        idx = int'(o / 8);
        return 1'b0;
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= 65535) ? 65535 : c + 1;
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        cur        = v;
        rst        = v.rst_n;
        arb_req    = v.a_req;
        arb_we     = v.a_we;
        arb_addr   = v.a_addr;
        arb_wdata  = v.a_wdata;
        host_req   = v.h_req;
        host_we    = v.h_we;
        host_idx   = v.h_idx;
        host_wdata = v.h_wdata;
    endtask

    task automatic checkOutput(input bit use_tbl);
        logic        ev;
        logic [63:0] ed;
        ev = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev         = 1'b1;
            last_rdata = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        ed = last_rdata;
        if (arb_valid === 1'b1) pulses++;
        compare("arb_valid", 64'(arb_valid), 64'(ev));
        compare("arb_rdata", arb_rdata, ed);
        compare("host_gnt", 64'(host_gnt), 64'(cur.h_req && !cur.a_req));
        compare("host_rvalid", 64'(host_rvalid), 64'(host_pend));
        if (host_chk) compare("host_rdata", host_rdata, host_exp);
        compare("rd_count", 64'(rd_count), 64'(m_rd));
        compare("wr_count", 64'(wr_count), 64'(m_wr));
        compare("err_count", 64'(err_count), 64'(m_err));
        if (use_tbl) begin
            compare("tbl_valid", 64'(arb_valid), 64'(cur.e_valid));
            compare("tbl_rdata", arb_rdata, cur.e_rdata);
            compare("tbl_gnt", 64'(host_gnt), 64'(cur.e_gnt));
        end
    endtask

    task automatic modelUpdate();
        int idx;
        bit f;
        if (!cur.rst_n) begin
            exp_q.delete();
            m_rd = 0; m_wr = 0; m_err = 0;
            last_rdata = '0;
            host_pend = 1'b0; host_chk = 1'b1; host_exp = '0;
            return;
        end
        host_pend = 1'b0;
        host_chk  = 1'b0;
        if (cur.a_req) begin
            f = decode(cur.a_addr, idx);
            if (f) begin
                m_err = sat_inc(m_err);
                if (!cur.a_we) exp_q.push_back('{due: cyc + LAT, data: ERRD});
            end else if (cur.a_we) begin
                mem_m[idx] = cur.a_wdata;
                m_wr = sat_inc(m_wr);
            end else begin
                exp_q.push_back('{due: cyc + LAT, data: mem_m[idx]});
                m_rd = sat_inc(m_rd);
            end
        end else if (cur.h_req) begin
            if (cur.h_we) begin
                mem_m[int'(cur.h_idx)] = cur.h_wdata;
            end else begin
                host_pend = 1'b1;
                host_chk  = 1'b1;
                host_exp  = mem_m[int'(cur.h_idx)];
            end
        end
    endtask

    task automatic finishCycle(input bit use_tbl);
        @(negedge clk);
        checkOutput(use_tbl);
        modelUpdate();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic runCycle(input vec_t v);
        applyStimulus(v);
        finishCycle(1'b0);
    endtask

    initial begin
        vec_t v;
        int   k;
        n_vec = 0; n_miss = 0; cyc = 0; pulses = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        applyStimulus(rst_v());
        @(posedge clk);
        #1;
        exp_q.delete();
        m_rd = 0; m_wr = 0; m_err = 0;
        last_rdata = '0; host_pend = 1'b0; host_chk = 1'b1; host_exp = '0;

        // Directed table: host preload then three back-to-back engine reads
        tbl[0] = exp_v(rst_v(),                          1'b0, 64'h0, 1'b0);
        tbl[1] = exp_v(host_v(1'b1, 0, 64'h1),           1'b0, 64'h0, 1'b1);
        tbl[2] = exp_v(host_v(1'b1, 1, 64'h2),           1'b0, 64'h0, 1'b1);
        tbl[3] = exp_v(host_v(1'b1, 2, 64'h3),           1'b0, 64'h0, 1'b1);
        v = eng_v(1'b0, waddr(0), '0); v.h_req = 1'b1;
        tbl[4] = exp_v(v,                                1'b0, 64'h0, 1'b0);
        tbl[5] = exp_v(eng_v(1'b0, waddr(1), '0),        1'b0, 64'h0, 1'b0);
        tbl[6] = exp_v(eng_v(1'b0, waddr(2), '0),        1'b1, 64'h1, 1'b0);
        tbl[7] = exp_v(idle_v(),                         1'b1, 64'h2, 1'b0);
        tbl[8] = exp_v(idle_v(),                         1'b1, 64'h3, 1'b0);
        tbl[9] = exp_v(idle_v(),                         1'b0, 64'h3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i]);
            finishCycle(1'b1);
        end
        compare("table_rd_count", 64'(rd_count), 64'd3);

        // 4096-word streaming read of a host-preloaded pattern
        runCycle(rst_v());
        for (int i = 0; i < 4096; i++) runCycle(host_v(1'b1, i, 64'(i) * 64'h1111));
        pulses = 0;
        for (int i = 0; i < 4096; i++) runCycle(eng_v(1'b0, waddr(i), '0));
        for (int i = 0; i < LAT + 2; i++) runCycle(idle_v());
        compare("stream_pulses", 64'(pulses), 64'd4096);
        compare("stream_rd_count", 64'(rd_count), 64'd4096);

        // 4096 engine writes of ~i, then host readback of both ends
        runCycle(rst_v());
        for (int i = 0; i < 4096; i++) runCycle(eng_v(1'b1, waddr(i), ~64'(i)));
        runCycle(host_v(1'b0, 0, '0));
        compare("wb_rvalid0", 64'(host_rvalid), 64'd1);
        compare("wb_rdata0", host_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        runCycle(host_v(1'b0, 4095, '0));
        compare("wb_rvalid4095", 64'(host_rvalid), 64'd1);
        compare("wb_rdata4095", host_rdata, 64'hFFFF_FFFF_FFFF_F000);
        compare("wb_wr_count", 64'(wr_count), 64'd4096);
        runCycle(idle_v());

        // Faulted accesses: misaligned, beyond depth, below base
        runCycle(rst_v());
        runCycle(eng_v(1'b0, waddr(0) + 48'd4, '0));
        runCycle(eng_v(1'b0, waddr(DEPTH), '0));
        compare("fault_valid_a", 64'(arb_valid), 64'd1);
        compare("fault_data_a", arb_rdata, ERRD);
        runCycle(idle_v());
        compare("fault_valid_b", 64'(arb_valid), 64'd1);
        compare("fault_data_b", arb_rdata, ERRD);
        runCycle(idle_v());
        compare("fault_err_count", 64'(err_count), 64'd2);
        compare("fault_rd_count", 64'(rd_count), 64'd0);
        runCycle(eng_v(1'b1, waddr(DEPTH), 64'h1234_5678_9ABC_DEF0));
        runCycle(eng_v(1'b0, BASE - 48'd8, '0));
        for (int i = 0; i < 3; i++) runCycle(idle_v());
        runCycle(host_v(1'b0, 0, '0));
        compare("fault_wr_dropped", host_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        compare("fault_err_count2", 64'(err_count), 64'd4);
        compare("fault_wr_count", 64'(wr_count), 64'd0);

        // Contention: host read held through a 10-read engine burst
        for (int i = 0; i < 10; i++) begin
            v = eng_v(1'b0, waddr(100 + i), '0);
            v.h_req = 1'b1; v.h_we = 1'b0; v.h_idx = MLOG'(5);
            applyStimulus(v);
            #1;
            compare("contend_gnt_low", 64'(host_gnt), 64'd0);
            finishCycle(1'b0);
        end
        applyStimulus(host_v(1'b0, 5, '0));
        #1;
        compare("contend_gnt_high", 64'(host_gnt), 64'd1);
        finishCycle(1'b0);
        compare("contend_rvalid", 64'(host_rvalid), 64'd1);
        compare("contend_rdata", host_rdata, ~64'd5);
        for (int i = 0; i < LAT + 2; i++) runCycle(idle_v());

        // Randomized mix around a small window plus boundary and fault addresses
        runCycle(host_v(1'b1, DEPTH - 1, 64'hA5A5_5A5A_0F0F_F0F0));
        runCycle(eng_v(1'b0, waddr(DEPTH - 1), '0));
        for (int n = 0; n < 600; n++) begin
            v = idle_v();
            v.a_req = ($urandom_range(0, 9) < 6);
            v.a_we  = 1'($urandom_range(0, 1));
            v.a_wdata = {$urandom, $urandom};
            k = int'($urandom_range(0, 20));
            if (k < 16)       v.a_addr = waddr(k);
            else if (k == 16) v.a_addr = waddr(int'($urandom_range(0, 15))) + 48'($urandom_range(1, 7));
            else if (k == 17) v.a_addr = waddr(DEPTH + int'($urandom_range(0, 3)));
            else if (k == 18) v.a_addr = BASE - 48'd8;
            else if (k == 19) v.a_addr = waddr(DEPTH - 1);
            else              v.a_addr = 48'hFFFF_FFFF_FFF8;
            v.h_req   = 1'($urandom_range(0, 1));
            v.h_we    = 1'($urandom_range(0, 1));
            v.h_idx   = ($urandom_range(0, 7) == 0) ? MLOG'(DEPTH - 1) : MLOG'($urandom_range(0, 15));
            v.h_wdata = {$urandom, $urandom};
            runCycle(v);
        end
        for (int i = 0; i < LAT + 2; i++) runCycle(idle_v());

        // Reset one cycle after three reads are issued
        runCycle(eng_v(1'b0, waddr(0), '0));
        runCycle(eng_v(1'b0, waddr(1), '0));
        runCycle(eng_v(1'b0, waddr(2), '0));
        runCycle(rst_v());
        pulses = 0;
        for (int i = 0; i < 6; i++) runCycle(idle_v());
        compare("midrst_pulses", 64'(pulses), 64'd0);
        compare("midrst_rd_count", 64'(rd_count), 64'd0);
        compare("midrst_wr_count", 64'(wr_count), 64'd0);
        compare("midrst_err_count", 64'(err_count), 64'd0);
        runCycle(host_v(1'b0, 2000, '0));
        compare("midrst_mem_kept", host_rdata, ~64'd2000);
        runCycle(idle_v());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
